// File: rtl/main_mem_arbiter.sv
// main_mem_arbiter: round-robin arbiter sharing one main-memory port between two pulse-protocol requesters
module main_mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int WDATA_W = 32,
  parameter int LINE_W  = 512,
  parameter int TIMEOUT = 1024
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [ADDR_W-1:0]  r0_addr,
  input  logic [WDATA_W-1:0] r0_wdata,
  input  logic               r0_read_req,
  input  logic               r0_write_req,
  output logic [LINE_W-1:0]  r0_rdata,
  output logic               r0_ready,
  input  logic [ADDR_W-1:0]  r1_addr,
  input  logic [WDATA_W-1:0] r1_wdata,
  input  logic               r1_read_req,
  input  logic               r1_write_req,
  output logic [LINE_W-1:0]  r1_rdata,
  output logic               r1_ready,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [WDATA_W-1:0] mem_data_out,
  output logic               mem_read_req,
  output logic               mem_write_req,
  input  logic [LINE_W-1:0]  mem_data_in,
  input  logic               mem_ready,
  output logic               busy,
  output logic               grant,
  output logic               timeout_err,
  output logic               overflow_err
);
  localparam int CW = $clog2(TIMEOUT);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
  state_t state, state_nx;
  logic [ADDR_W-1:0] in_addr [2];
  logic [WDATA_W-1:0] in_wdata [2];
  logic [ADDR_W-1:0] slot_addr [2];
  logic [WDATA_W-1:0] slot_wdata [2];
  logic [1:0] slot_wr, slot_vld, req, wr, clr;
  logic grant_q, last_grant, winner, done, tmo, act, tmo_err_q, ovf_err_q;
  logic [CW-1:0] cnt;
  assign in_addr[0] = r0_addr;
  assign in_addr[1] = r1_addr;
  assign in_wdata[0] = r0_wdata;
  assign in_wdata[1] = r1_wdata;
  assign req = {r1_read_req | r1_write_req, r0_read_req | r0_write_req};
  assign wr = {r1_write_req, r0_write_req};
  assign winner = &slot_vld ? ~last_grant : slot_vld[1];
  assign done = state == WAIT && (mem_ready || cnt == CW'(TIMEOUT - 1));
  assign tmo = done && !mem_ready;
  assign clr = done ? (grant_q ? 2'b10 : 2'b01) : 2'b00;
  assign act = !rst && state != IDLE;
  always_comb begin
    state_nx = state;
    state_nx = state == IDLE ? (|slot_vld ? ISSUE : IDLE) : state == ISSUE ? WAIT : done ? IDLE : WAIT;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      slot_vld <= '0;
      grant_q <= 1'b0;
      last_grant <= 1'b1;
      cnt <= '0;
      tmo_err_q <= 1'b0;
      ovf_err_q <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == IDLE && |slot_vld) grant_q <= winner;
      cnt <= state == WAIT ? cnt + 1'b1 : '0;
      if (done) last_grant <= grant_q;
      if (tmo) tmo_err_q <= 1'b1;
      for (int i = 0; i < 2; i++) begin
        if (req[i] && (!slot_vld[i] || clr[i])) begin
          slot_vld[i] <= 1'b1;
          slot_addr[i] <= in_addr[i];
          slot_wdata[i] <= in_wdata[i];
          slot_wr[i] <= wr[i];
        end else if (clr[i]) begin
          slot_vld[i] <= 1'b0;
        end
        if (req[i] && slot_vld[i] && !clr[i]) ovf_err_q <= 1'b1;
      end
    end
  end
  assign busy = act;
  assign grant = grant_q;
  assign mem_addr = act ? slot_addr[grant_q] : '0;
  assign mem_data_out = act ? slot_wdata[grant_q] : '0;
  assign mem_read_req = !rst && state == ISSUE && !slot_wr[grant_q];
  assign mem_write_req = !rst && state == ISSUE && slot_wr[grant_q];
  assign r0_ready = !rst && done && !grant_q;
  assign r1_ready = !rst && done && grant_q;
  assign r0_rdata = tmo ? '0 : mem_data_in;
  assign r1_rdata = tmo ? '0 : mem_data_in;
  assign timeout_err = !rst && tmo_err_q;
  assign overflow_err = !rst && ovf_err_q;
endmodule
